// File: rtl/des_pkg.sv
// Shared constants for the 3DES AHB-Lite slave: register map, bus encodings
// and the data-phase state enum.
package des_pkg;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_KEY1 = 3'd1;
  localparam logic [2:0] REG_KEY2 = 3'd2;
  localparam logic [2:0] REG_KEY3 = 3'd3;
  localparam logic [2:0] REG_DATA = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_64 = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    STALL,
    ERR1,
    ERR2
  } bus_phase_e;

endpackage

// File: rtl/des_sync_fifo.sv
// Synchronous FIFO with log2(DEPTH)+1 bit pointers; a push on a full FIFO is
// accepted when a pop happens in the same cycle.
module des_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_INC;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_INC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/des_ahb_slave_fifo.sv
// AHB-Lite slave front-end for the 3DES core: mode/key registers, input and
// output chunk FIFOs, status register. DES_READ_TIMEOUT_EN enables the read timeout and irq.
module des_ahb_slave_fifo
  import des_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int WAIT_MAX  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_enc_dec,
  output logic [63:0]       core_key1,
  output logic [63:0]       core_key2,
  output logic [63:0]       core_key3,
  input  logic              core_busy,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  input  logic [DATA_W-1:0] core_out_data,
  output logic              irq
);

  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;
  localparam int STAT_W = OUT_CW + IN_CW + 1;

  bus_phase_e        phase_q, phase_d, phase_hold;
  logic [2:0]        reg_q, reg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mode_q, mode_d;
  logic [63:0]       key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;

  logic              in_full, in_empty, in_push;
  logic [IN_CW-1:0]  in_count;
  logic              out_full, out_empty, out_push, out_pop;
  logic [OUT_CW-1:0] out_count;
  logic [DATA_W-1:0] out_head;

  logic              addr_valid, cfg_idle, bypass, done, rsp_err;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STAT_W-1:0] stat;

`ifdef DES_READ_TIMEOUT_EN
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);
  localparam logic [WCNT_W-1:0] WAIT_INC  = 1;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX != 0);
`endif

  logic unused_addr;
  assign unused_addr = ^{HADDR[ADDR_W-1:13], HADDR[9:0]};

  assign addr_valid     = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign wdata          = (phase_q == STALL) ? wdata_q : HWDATA;
  assign core_in_valid  = !in_empty;
  assign core_out_ready = !out_full;
  assign cfg_idle       = !core_busy && in_empty && out_empty && !core_in_valid;
  assign out_push       = core_out_valid && !bypass;
  assign stat           = {out_count, in_count, core_busy};

  assign HREADYOUT    = done;
  assign HRESP        = rsp_err;
  assign HRDATA       = rdata;
  assign core_enc_dec = mode_q;
  assign core_key1    = key1_q;
  assign core_key2    = key2_q;
  assign core_key3    = key3_q;

  // Data-phase response and side effects; kept free of HREADY so that an
  // interconnect feeding HREADYOUT back into HREADY forms no loop.
  always_comb begin
    done       = 1'b1;
    rsp_err    = 1'b0;
    rdata      = '0;
    in_push    = 1'b0;
    out_pop    = 1'b0;
    bypass     = 1'b0;
    phase_hold = phase_q;
    wdata_d    = wdata_q;
    mode_d     = mode_q;
    key1_d     = key1_q;
    key2_d     = key2_q;
    key3_d     = key3_q;
`ifdef DES_READ_TIMEOUT_EN
    wait_cnt_d = '0;
`endif
    case (phase_q)
      WRITE, STALL: begin
        case (reg_q)
          REG_CTRL: if (cfg_idle) mode_d = wdata[0];        else done = 1'b0;
          REG_KEY1: if (cfg_idle) key1_d = wdata[63:0];     else done = 1'b0;
          REG_KEY2: if (cfg_idle) key2_d = wdata[63:0];     else done = 1'b0;
          REG_KEY3: if (cfg_idle) key3_d = wdata[63:0];     else done = 1'b0;
          REG_DATA: if (!in_full || core_in_ready) in_push = 1'b1; else done = 1'b0;
          default: ;
        endcase
        if (!done) begin
          phase_hold = STALL;
          wdata_d    = wdata;
        end
      end
      READ: begin
        case (reg_q)
          REG_CTRL: begin
            if (!out_empty) begin
              rdata   = out_head;
              out_pop = 1'b1;
            end else if (core_out_valid) begin
              rdata  = core_out_data;
              bypass = 1'b1;
            end else begin
              done = 1'b0;
`ifdef DES_READ_TIMEOUT_EN
              wait_cnt_d = wait_cnt_q + WAIT_INC;
              if (wait_cnt_q == WAIT_LAST) phase_hold = ERR1;
`endif
            end
          end
          REG_STAT: rdata = DATA_W'(stat);
          default: ;
        endcase
      end
      ERR1: begin
        done       = 1'b0;
        rsp_err    = 1'b1;
        phase_hold = ERR2;
      end
      ERR2: rsp_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    phase_d = phase_hold;
    reg_d   = reg_q;
    if (done) begin
      phase_d = IDLE;
      if (addr_valid) begin
        reg_d = HADDR[12:10];
        if (HSIZE != HSIZE_64) phase_d = ERR1;
        else if (HWRITE)       phase_d = WRITE;
        else                   phase_d = READ;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      phase_q    <= IDLE;
      reg_q      <= '0;
      wdata_q    <= '0;
      mode_q     <= 1'b0;
      key1_q     <= '0;
      key2_q     <= '0;
      key3_q     <= '0;
`ifdef DES_READ_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      phase_q    <= phase_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      key1_q     <= key1_d;
      key2_q     <= key2_d;
      key3_q     <= key3_d;
`ifdef DES_READ_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

`ifdef DES_READ_TIMEOUT_EN
  assign irq = !out_empty;
`else
  assign irq = 1'b0;
`endif

  des_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(IN_DEPTH)
  ) u_in_fifo (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (in_push),
    .push_data(wdata),
    .pop      (core_in_ready),
    .pop_data (core_in_data),
    .full     (in_full),
    .empty    (in_empty),
    .count    (in_count)
  );

  des_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(OUT_DEPTH)
  ) u_out_fifo (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (out_push),
    .push_data(core_out_data),
    .pop      (out_pop),
    .pop_data (out_head),
    .full     (out_full),
    .empty    (out_empty),
    .count    (out_count)
  );

endmodule
